// File: rtl/mmio_uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package mmio_uart_pkg;

    // Transmit FSM states; StParity is only reachable with MMIO_UART_PARITY_EN.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

    // Register offsets from BASE_ADDR.
    localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

    // STATUS bit positions.
    localparam int unsigned STAT_EMPTY     = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_BUSY      = 2;
    localparam int unsigned STAT_OVERFLOW  = 3;
    localparam int unsigned STAT_COUNT_LSB = 8;

    // Even parity: XOR of the data bits.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset. A push while full is
// accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CntW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Pointer and occupancy registers; reset flushes the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS decoder, byte FIFO, sticky
// overflow flag and 8N1 serialiser. Define MMIO_UART_PARITY_EN to insert an
// even-parity bit between the data bits and the stop bit.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] daddr_i,
    input  logic [31:0] dwdata_i,
    input  logic [3:0]  we_i,
    output logic        mmio_hit_o,
    output logic [31:0] mmio_rdata_o,
    output logic        txd_o
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    uart_state_e      state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             overflow_q, overflow_d;

    logic             push, pop, clr_ovf;
    logic             fifo_full, fifo_empty;
    logic [7:0]       fifo_data;
    logic [CntW-1:0]  fifo_count;
    logic [31:0]      status;
    logic             baud_done;

    // Store-data bits with no function in this block.
    logic unused_bits;
    assign unused_bits = ^{dwdata_i[31:8], we_i[3:1]};

    // Address decode and register strobes.
    always_comb begin
        mmio_hit_o = (daddr_i[31:3] == BASE_ADDR[31:3]);
        push       = mmio_hit_o && (daddr_i[2] == TXDATA_OFS[2]) && we_i[0];
        clr_ovf    = mmio_hit_o && (daddr_i[2] == STATUS_OFS[2]) && we_i[0] && dwdata_i[3];
    end

    // STATUS word assembled from current registered state.
    always_comb begin
        status                           = '0;
        status[STAT_EMPTY]               = fifo_empty;
        status[STAT_FULL]                = fifo_full;
        status[STAT_BUSY]                = (state_q != StIdle);
        status[STAT_OVERFLOW]            = overflow_q;
        status[STAT_COUNT_LSB +: 8]      = 8'(fifo_count);
        mmio_rdata_o = (daddr_i == BASE_ADDR + STATUS_OFS) ? status : 32'h0;
    end

    sync_fifo #(
        .Width (8),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (dwdata_i[7:0]),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Sticky overflow: set on a dropped push, cleared by a STATUS write of bit 3.
    always_comb begin
        overflow_d = overflow_q;
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    assign baud_done = (baud_q == BaudLast);

    // Transmit FSM next-state, baud/bit counters and registered line level.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BaudW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_data;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef MMIO_UART_PARITY_EN
            StParity: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = StIdle;
            end
        endcase

        // Line level follows the state being entered so txd_o is glitch-free.
        case (state_d)
            StStart:  txd_d = 1'b0;
            StData:   txd_d = shift_d[bit_d];
`ifdef MMIO_UART_PARITY_EN
            StParity: txd_d = even_parity(shift_d);
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    // State registers; reset aborts any frame and returns the line to idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            overflow_q <= overflow_d;
        end
    end

    assign txd_o = txd_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef MMIO_UART_PARITY_EN
    localparam int NSEG = 11;
`else
    localparam int NSEG = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] daddr, dwdata;
    logic [3:0]  we;
    logic        mmio_hit;
    logic [31:0] mmio_rdata;
    logic        txd;

    int checks = 0;
    int failures = 0;

    logic [7:0] rx_q [$];
    logic       rx_par_q [$];
    logic       rx_stop_q [$];

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .daddr_i      (daddr),
        .dwdata_i     (dwdata),
        .we_i         (we),
        .mmio_hit_o   (mmio_hit),
        .mmio_rdata_o (mmio_rdata),
        .txd_o        (txd)
    );

    // Line receiver: samples each bit in its middle and queues decoded frames.
    initial begin : rx_monitor
        logic [7:0] b;
        logic       p;
        logic       s;
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b0 && txd === 1'b0) begin
                repeat (CPB + CPB / 2) @(posedge clk);
                #1;
                b[0] = txd;
                for (int i = 1; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    #1;
                    b[i] = txd;
                end
                p = 1'b0;
`ifdef MMIO_UART_PARITY_EN
                repeat (CPB) @(posedge clk);
                #1;
                p = txd;
`endif
                repeat (CPB) @(posedge clk);
                #1;
                s = txd;
                rx_q.push_back(b);
                rx_par_q.push_back(p);
                rx_stop_q.push_back(s);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic bus_idle();
        daddr  = 32'h0;
        dwdata = 32'h0;
        we     = 4'b0000;
    endtask

    // Presents one store; it is sampled at the next rising edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        daddr  = a;
        dwdata = d;
        we     = be;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic read_status(output logic [31:0] v);
        daddr = BASE + 32'h4;
        we    = 4'b0000;
        #1;
        v     = mmio_rdata;
        daddr = 32'h0;
    endtask

    task automatic wait_rx(input int n, input int budget, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (rx_q.size() >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] st;
        rst = 1'b1;
        bus_idle();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            daddr  = BASE | ($urandom_range(0, 1) << 2);
            dwdata = $urandom;
            we     = 4'($urandom);
        end
        bus_idle();
        @(posedge clk);
        #1;
        checks++;
        if (txd !== 1'b1) begin
            failures++;
            $display("FAIL reset_txd: got %b, required 1", txd);
        end
        read_status(st);
        checks++;
        if (st !== 32'h0000_0001) begin
            failures++;
            $display("FAIL reset_status: got %h, required 00000001", st);
        end
        daddr = BASE + 32'h4;
        #1;
        checks++;
        if (mmio_hit !== 1'b1) begin
            failures++;
            $display("FAIL reset_hit: got %b, required 1", mmio_hit);
        end
        bus_idle();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_byte();
        logic [7:0]  d;
        logic [31:0] st;
        logic        exp;
        int          seg;
        d = 8'h55;
        rx_q.delete(); rx_par_q.delete(); rx_stop_q.delete();
        store(BASE, 32'hFFFF_FF55, 4'b0001);
        read_status(st);
        checks++;
        if (st !== 32'h0000_0100 || txd !== 1'b1) begin
            failures++;
            $display("FAIL single_after_write: got status %h txd %b, required 00000100 txd 1", st, txd);
        end
        for (int k = 1; k <= NSEG * CPB; k++) begin
            @(posedge clk);
            #1;
            seg = (k - 1) / CPB;
            if (seg == 0) exp = 1'b0;
            else if (seg <= 8) exp = d[seg-1];
            else if (seg == 9 && NSEG == 11) exp = ^d;
            else exp = 1'b1;
            checks++;
            if (txd !== exp) begin
                failures++;
                $display("FAIL single_txd cycle %0d: got %b, required %b", k, txd, exp);
            end
            read_status(st);
            checks++;
            if (st !== 32'h0000_0005) begin
                failures++;
                $display("FAIL single_busy cycle %0d: got %h, required 00000005", k, st);
            end
        end
        @(posedge clk);
        #1;
        read_status(st);
        checks++;
        if (st !== 32'h0000_0001 || txd !== 1'b1) begin
            failures++;
            $display("FAIL single_done: got status %h txd %b, required 00000001 txd 1", st, txd);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] st;
        logic        ok;
        rx_q.delete(); rx_par_q.delete(); rx_stop_q.delete();
        for (int i = 0; i < 10; i++) begin
            store(BASE, 32'(i), 4'b0001);
            if (i == 8) begin
                read_status(st);
                checks++;
                if (st !== 32'h0000_0806) begin
                    failures++;
                    $display("FAIL ovf_full: got %h, required 00000806", st);
                end
            end
        end
        read_status(st);
        checks++;
        if (st !== 32'h0000_080E) begin
            failures++;
            $display("FAIL ovf_set: got %h, required 0000080e", st);
        end
        wait_rx(9, 700, ok);
        repeat (60) @(posedge clk);
        #1;
        checks++;
        if (!ok || rx_q.size() != 9) begin
            failures++;
            $display("FAIL ovf_frames: got %0d frames, required 9", rx_q.size());
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (i >= rx_q.size() || rx_q[i] !== 8'(i) || rx_stop_q[i] !== 1'b1) begin
                failures++;
                $display("FAIL ovf_byte %0d: got %h, required %h", i,
                         (i < rx_q.size()) ? rx_q[i] : 8'hxx, 8'(i));
            end
        end
        read_status(st);
        checks++;
        if (st !== 32'h0000_0009) begin
            failures++;
            $display("FAIL ovf_sticky: got %h, required 00000009", st);
        end
        store(BASE + 32'h4, 32'hFFFF_FFF7, 4'b0001);
        read_status(st);
        checks++;
        if (st !== 32'h0000_0009) begin
            failures++;
            $display("FAIL ovf_noclear: got %h, required 00000009", st);
        end
        store(BASE + 32'h4, 32'h0000_0008, 4'b0001);
        read_status(st);
        checks++;
        if (st !== 32'h0000_0001) begin
            failures++;
            $display("FAIL ovf_clear: got %h, required 00000001", st);
        end
    endtask

    task automatic test_push_pop_same_edge();
        logic [31:0] st;
        logic        ok;
        logic [7:0]  exp;
        rx_q.delete(); rx_par_q.delete(); rx_stop_q.delete();
        for (int i = 0; i < 9; i++) begin
            store(BASE, 32'h0000_00A0 + 32'(i), 4'b0001);
        end
        read_status(st);
        checks++;
        if (st !== 32'h0000_0806) begin
            failures++;
            $display("FAIL pp_full: got %h, required 00000806", st);
        end
        // Land on the cycle after the first frame's stop bit: FSM idle, FIFO full.
        repeat (NSEG * CPB + 1 - 8) @(posedge clk);
        #1;
        read_status(st);
        checks++;
        if (st !== 32'h0000_0802) begin
            failures++;
            $display("FAIL pp_idle_full: got %h, required 00000802", st);
        end
        store(BASE, 32'h0000_00B5, 4'b0001);
        read_status(st);
        checks++;
        if (st !== 32'h0000_0806) begin
            failures++;
            $display("FAIL pp_accept: got %h, required 00000806", st);
        end
        wait_rx(10, 700, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL pp_frames: got %0d frames, required 10", rx_q.size());
        end
        for (int i = 0; i < 10; i++) begin
            exp = (i < 9) ? 8'hA0 + 8'(i) : 8'hB5;
            checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp) begin
                failures++;
                $display("FAIL pp_byte %0d: got %h, required %h", i,
                         (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp);
            end
        end
        repeat (10) @(posedge clk);
        #1;
        read_status(st);
        checks++;
        if (st !== 32'h0000_0001) begin
            failures++;
            $display("FAIL pp_end: got %h, required 00000001", st);
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [31:0] st;
        int          lows;
        store(BASE, 32'h37, 4'b0001);
        store(BASE, 32'h11, 4'b0001);
        store(BASE, 32'h22, 4'b0001);
        store(BASE, 32'h33, 4'b0001);
        read_status(st);
        checks++;
        if (st !== 32'h0000_0304) begin
            failures++;
            $display("FAIL mfr_queued: got %h, required 00000304", st);
        end
        repeat (14) @(posedge clk);
        #1;
        checks++;
        if (txd !== 1'b0) begin
            failures++;
            $display("FAIL mfr_bit3: got %b, required 0", txd);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (txd !== 1'b1) begin
            failures++;
            $display("FAIL mfr_txd: got %b, required 1", txd);
        end
        read_status(st);
        checks++;
        if (st !== 32'h0000_0001) begin
            failures++;
            $display("FAIL mfr_status: got %h, required 00000001", st);
        end
        lows = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (txd !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
            failures++;
            $display("FAIL mfr_quiet: got %0d non-idle cycles, required 0", lows);
        end
        rx_q.delete(); rx_par_q.delete(); rx_stop_q.delete();
    endtask

    task automatic test_decode();
        logic [31:0] st;
        int          lows;
        daddr = BASE + 32'h8;
        #1;
        checks++;
        if (mmio_hit !== 1'b0) begin
            failures++;
            $display("FAIL dec_hit_1008: got %b, required 0", mmio_hit);
        end
        daddr = BASE - 32'h4;
        #1;
        checks++;
        if (mmio_hit !== 1'b0) begin
            failures++;
            $display("FAIL dec_hit_0ffc: got %b, required 0", mmio_hit);
        end
        daddr = BASE;
        #1;
        checks++;
        if (mmio_hit !== 1'b1 || mmio_rdata !== 32'h0) begin
            failures++;
            $display("FAIL dec_txdata_read: got hit %b data %h, required 1 00000000",
                     mmio_hit, mmio_rdata);
        end
        bus_idle();
        store(BASE + 32'h8, 32'h41, 4'b0001);
        read_status(st);
        checks++;
        if (st !== 32'h0000_0001) begin
            failures++;
            $display("FAIL dec_1008_push: got %h, required 00000001", st);
        end
        store(BASE, 32'h41, 4'b0010);
        read_status(st);
        checks++;
        if (st !== 32'h0000_0001) begin
            failures++;
            $display("FAIL dec_we1_push: got %h, required 00000001", st);
        end
        lows = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (txd !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
            failures++;
            $display("FAIL dec_quiet: got %0d non-idle cycles, required 0", lows);
        end
    endtask

`ifdef MMIO_UART_PARITY_EN
    task automatic test_parity();
        logic ok;
        rx_q.delete(); rx_par_q.delete(); rx_stop_q.delete();
        store(BASE, 32'h07, 4'b0001);
        store(BASE, 32'h03, 4'b0001);
        wait_rx(2, 200, ok);
        checks++;
        if (!ok || rx_q[0] !== 8'h07 || rx_par_q[0] !== 1'b1 || rx_stop_q[0] !== 1'b1) begin
            failures++;
            $display("FAIL parity_07: got %h par %b, required 07 par 1", rx_q[0], rx_par_q[0]);
        end
        checks++;
        if (!ok || rx_q[1] !== 8'h03 || rx_par_q[1] !== 1'b0 || rx_stop_q[1] !== 1'b1) begin
            failures++;
            $display("FAIL parity_03: got %h par %b, required 03 par 0", rx_q[1], rx_par_q[1]);
        end
        repeat (10) @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        bus_idle();
        rst = 1'b1;
        test_reset();
        test_single_byte();
        test_overflow();
        test_push_pop_same_edge();
        test_mid_frame_reset();
        test_decode();
`ifdef MMIO_UART_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
